// File: rtl/fb_mem_arbiter_if.sv
// fb_mem_arbiter_if
//   Bundles the signals between the framebuffer arbiter and its neighbours:
//   the scanout read requester, the PPU write requester, and the single-port
//   pixel RAM.
//   Modports:
//     master - requesters and RAM side (drives requests, addresses, write data
//              and RAM read data; observes grants, read return and RAM controls)
//     slave  - arbiter side (the inverse of master)
interface fb_mem_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 2
);
  logic          r0_req;
  logic [AW-1:0] r0_addr;
  logic          r0_gnt;
  logic          r0_rvalid;
  logic [DW-1:0] r0_rdata;

  logic          w1_req;
  logic [AW-1:0] w1_addr;
  logic [DW-1:0] w1_wdata;
  logic          w1_gnt;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output r0_req, r0_addr, w1_req, w1_addr, w1_wdata, mem_rdata,
    input  r0_gnt, r0_rvalid, r0_rdata, w1_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  r0_req, r0_addr, w1_req, w1_addr, w1_wdata, mem_rdata,
    output r0_gnt, r0_rvalid, r0_rdata, w1_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/fb_mem_arbiter.sv
// fb_mem_arbiter
//   Shares the single-port framebuffer pixel RAM between the DVI scanout
//   reader (requester 0) and the PPU pixel writer (requester 1). After reset
//   is released, all traffic is held off for 16 cycles. From then on, access
//   is granted round-robin, with bursts bounded to MAX_BURST while the other
//   side waits.
//   Ports:
//     fbclk             - clock
//     fbclk_rst_cause_b - asynchronous active-low reset
//     bus               - slave side of fb_mem_arbiter_if (requests, grants,
//                         read return, registered RAM controls)
//     rst_done          - release sequence finished, arbiter live
module fb_mem_arbiter #(
  parameter int AW        = 15,
  parameter int DW        = 2,
  parameter int MAX_BURST = 8,
  parameter int RD_LAT    = 1
) (
  input  logic              fbclk,
  input  logic              fbclk_rst_cause_b,
  fb_mem_arbiter_if.slave   bus,
  output logic              rst_done
);

  localparam int            BW   = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_RST,
    ST_IDLE,
    ST_OWN0,
    ST_OWN1
  } state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [3:0]      rcnt_q, rcnt_d;
  logic            rst_done_q, rst_done_d;

  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

  logic            gnt0, gnt1;
  logic            r0, r1;

  assign r0 = bus.r0_req;
  assign r1 = bus.w1_req;

  // Arbitration: next state and same-cycle grants
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    bcnt_d     = bcnt_q;
    rcnt_d     = rcnt_q;
    rst_done_d = rst_done_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;

    case (state_q)
      ST_RST: begin
        if (rcnt_q == 4'd15) begin
          state_d    = ST_IDLE;
          rst_done_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end

      ST_IDLE: begin
        // When both ask, the one not served last wins.
        if (r0 && (!r1 || last_q)) begin
          gnt0    = 1'b1;
          state_d = ST_OWN0;
          bcnt_d  = BW'(1);
        end else if (r1) begin
          gnt1    = 1'b1;
          state_d = ST_OWN1;
          bcnt_d  = BW'(1);
        end
      end

      ST_OWN0: begin
        // The burst limit only applies while the other side is waiting.
        if (r0 && ((bcnt_q < BMAX) || !r1)) begin
          gnt0 = 1'b1;
          if (bcnt_q < BMAX) bcnt_d = bcnt_q + BW'(1);
        end else if (r1) begin
          gnt1    = 1'b1;
          state_d = ST_OWN1;
          bcnt_d  = BW'(1);
          last_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end
      end

      ST_OWN1: begin
        if (r1 && ((bcnt_q < BMAX) || !r0)) begin
          gnt1 = 1'b1;
          if (bcnt_q < BMAX) bcnt_d = bcnt_q + BW'(1);
        end else if (r0) begin
          gnt0    = 1'b1;
          state_d = ST_OWN0;
          bcnt_d  = BW'(1);
          last_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end
      end

      default: state_d = ST_RST;
    endcase
  end

  // RAM command stage and read-return pipe
  always_comb begin
    mem_en_d    = gnt0 | gnt1;
    mem_we_d    = gnt1;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (gnt0) begin
      mem_addr_d  = bus.r0_addr;
      mem_wdata_d = '0;
    end else if (gnt1) begin
      mem_addr_d  = bus.w1_addr;
      mem_wdata_d = bus.w1_wdata;
    end
    // Shift towards the MSB; the MSB is the tail that flags returned data.
    rd_pipe_d = RD_LAT'({rd_pipe_q, (mem_en_q & ~mem_we_q)});
  end

  always_ff @(posedge fbclk or negedge fbclk_rst_cause_b) begin
    if (!fbclk_rst_cause_b) begin
      state_q     <= ST_RST;
      last_q      <= 1'b1;
      bcnt_q      <= '0;
      rcnt_q      <= '0;
      rst_done_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      bcnt_q      <= bcnt_d;
      rcnt_q      <= rcnt_d;
      rst_done_q  <= rst_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign bus.r0_gnt    = gnt0;
  assign bus.w1_gnt    = gnt1;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.r0_rvalid = rd_pipe_q[RD_LAT-1];
  // Data is forced to zero outside valid cycles so stale RAM output never leaks.
  assign bus.r0_rdata  = rd_pipe_q[RD_LAT-1] ? bus.mem_rdata : '0;
  assign rst_done      = rst_done_q;

endmodule
